// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI write-address arbiter: master indices, FSM states, default queue depth.
package axi_arb_pkg;

  localparam int unsigned DefaultDepth = 4;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DMA = 1'b1
  } mst_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axi_wr_arbiter_fifo.sv
// Small synchronous FIFO with occupancy count; pushes when full and pops when empty are dropped.
module axi_wr_arbiter_fifo #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI AW arbiter with AW->W ordering queue. Define AXI_WR_ARB_RR_EN for round-robin
// arbitration; otherwise DMA has fixed priority over CPU.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             m0_awvalid_i,
  input  logic             m1_awvalid_i,
  input  logic             awready_i,
  output logic [1:0]       aw_gnt_o,
  output logic             awvalid_o,
  input  logic             wvalid_i,
  input  logic             wready_i,
  input  logic             wlast_i,
  output logic             w_sel_o,
  output logic             w_sel_valid_o,
  output logic [CNT_W-1:0] outstanding_o
);

  arb_state_e state_q, state_d;
  mst_e       lock_mst_q, lock_mst_d;
  mst_e       pick, gnt_mst;
  logic       gnt_vld, sel_awvalid, aw_hs;
  logic       q_full, q_empty, q_head, q_pop;

`ifdef AXI_WR_ARB_RR_EN
  // Set when DMA wins a tie next, i.e. CPU completed the last handshake.
  logic dma_prio_q;

  always_comb begin
    pick = MST_CPU;
    if (m0_awvalid_i && m1_awvalid_i) begin
      pick = dma_prio_q ? MST_DMA : MST_CPU;
    end else if (m1_awvalid_i) begin
      pick = MST_DMA;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dma_prio_q <= 1'b0;
    end else if (aw_hs) begin
      dma_prio_q <= (gnt_mst == MST_CPU);
    end
  end
`else
  assign pick = m1_awvalid_i ? MST_DMA : MST_CPU;
`endif

  assign gnt_mst     = (state_q == StLocked) ? lock_mst_q : pick;
  assign sel_awvalid = (gnt_mst == MST_DMA) ? m1_awvalid_i : m0_awvalid_i;
  assign gnt_vld     = rst_ni && !q_full &&
                       ((state_q == StLocked) || m0_awvalid_i || m1_awvalid_i);

  assign aw_gnt_o  = !gnt_vld ? 2'b00 : ((gnt_mst == MST_DMA) ? 2'b10 : 2'b01);
  assign awvalid_o = gnt_vld && sel_awvalid;
  assign aw_hs     = awvalid_o && awready_i;

  always_comb begin
    state_d    = state_q;
    lock_mst_d = lock_mst_q;
    case (state_q)
      StIdle: begin
        // A stalled request pins the grant so AW payload cannot switch under the slave.
        if (awvalid_o && !awready_i) begin
          state_d    = StLocked;
          lock_mst_d = gnt_mst;
        end
      end
      StLocked: begin
        if (aw_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      lock_mst_q <= MST_CPU;
    end else begin
      state_q    <= state_d;
      lock_mst_q <= lock_mst_d;
    end
  end

  assign w_sel_valid_o = rst_ni && !q_empty;
  assign w_sel_o       = q_head;
  assign q_pop         = w_sel_valid_o && wvalid_i && wready_i && wlast_i;

  axi_wr_arbiter_fifo #(
    .DATA_W (1),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_order_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_hs),
    .wdata_i (gnt_mst),
    .pop_i   (q_pop),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (outstanding_o)
  );

endmodule
